// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: main sequencing FSM of the multi-cycle RV32I core.
//
// Sits between the instruction register and the alu_dec/ALU/regfile/memory
// datapath. Each cycle it selects ALU operands, tells alu_dec the instruction
// format (or forces an ADD), and strobes PC/OldPC/IR/regfile/memory. It counts
// retired instructions and traps on illegal opcodes, SYSTEM or memory timeouts.
//
// Ports:
//   clk, reset      clock; synchronous active-high reset
//   opcode          IR[6:0]
//   br_taken        branch comparator result for the current IR
//   mem_ready       memory completes the current access this cycle
//   pc_write        load PC from the pc_src mux
//   old_pc_write    latch OldPC <- PC
//   ir_write        latch IR <- memory read data
//   pc_src          0 = ALU result, 1 = ALUOut
//   adr_src         memory address: 0 = PC, 1 = ALUOut
//   mem_valid       memory request; mem_we marks it as a write
//   reg_write       register-file write enable
//   result_src      0 = ALUOut, 1 = mem rdata, 2 = ALU result
//   alu_src_a       0 = PC, 1 = OldPC, 2 = rs1, 3 = zero
//   alu_src_b       0 = rs2, 1 = imm, 2 = constant 4
//   alu_force_add   1 = ALU adds, 0 = alu_dec decides
//   fmt             instruction format for alu_dec (10 = unknown)
//   fault_code      0 none, 1 illegal, 2 memory timeout, 3 SYSTEM
//   instret         retired-instruction count (wraps)
module multicycle_ctrl #(
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic             br_taken,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             old_pc_write,
    output logic             ir_write,
    output logic             pc_src,
    output logic             adr_src,
    output logic             mem_valid,
    output logic             mem_we,
    output logic             reg_write,
    output logic [1:0]       result_src,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic             alu_force_add,
    output logic [3:0]       fmt,
    output logic [1:0]       fault_code,
    output logic [CNT_W-1:0] instret
);

    localparam int unsigned WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_SYS   = 7'b1110011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    typedef enum logic [3:0] {
        st_fetch, st_decode, st_exec_r, st_exec_i, st_exec_u, st_alu_wb,
        st_mem_adr, st_mem_rd, st_mem_wb, st_mem_wr, st_branch,
        st_jalr_adr, st_jump, st_trap
    } state_t;

    state_t             state_q, state_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [1:0]         fault_q, fault_d;
    logic [CNT_W-1:0]   instret_q, instret_d;
    logic               retire;
    logic               waiting;

    assign fault_code = fault_q;
    assign instret    = instret_q;

    always_comb begin
        unique case (opcode)
            OP_R:     fmt = 4'd0;
            OP_I:     fmt = 4'd1;
            OP_LOAD:  fmt = 4'd2;
            OP_SYS:   fmt = 4'd3;
            OP_STORE: fmt = 4'd4;
            OP_BR:    fmt = 4'd5;
            OP_JAL:   fmt = 4'd6;
            OP_JALR:  fmt = 4'd7;
            OP_LUI:   fmt = 4'd8;
            OP_AUIPC: fmt = 4'd9;
            default:  fmt = 4'd10;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        fault_d       = fault_q;
        retire        = 1'b0;
        waiting       = 1'b0;
        pc_write      = 1'b0;
        old_pc_write  = 1'b0;
        ir_write      = 1'b0;
        pc_src        = 1'b0;
        adr_src       = 1'b0;
        mem_valid     = 1'b0;
        mem_we        = 1'b0;
        reg_write     = 1'b0;
        result_src    = 2'd0;
        alu_src_a     = 2'd0;
        alu_src_b     = 2'd0;
        alu_force_add = 1'b0;

        unique case (state_q)
            st_fetch: begin
                // ALU computes PC+4 while memory returns the instruction.
                waiting       = 1'b1;
                mem_valid     = 1'b1;
                alu_src_b     = 2'd2;
                alu_force_add = 1'b1;
                if (mem_ready) begin
                    ir_write     = 1'b1;
                    pc_write     = 1'b1;
                    old_pc_write = 1'b1;
                    state_d      = st_decode;
                end
            end
            st_decode: begin
                // ALUOut <- OldPC + imm: the branch/JAL target.
                alu_src_a     = 2'd1;
                alu_src_b     = 2'd1;
                alu_force_add = 1'b1;
                unique case (opcode)
                    OP_R:               state_d = st_exec_r;
                    OP_I:               state_d = st_exec_i;
                    OP_LOAD, OP_STORE:  state_d = st_mem_adr;
                    OP_BR:              state_d = st_branch;
                    OP_JAL:             state_d = st_jump;
                    OP_JALR:            state_d = st_jalr_adr;
                    OP_LUI, OP_AUIPC:   state_d = st_exec_u;
                    OP_SYS: begin
                        state_d = st_trap;
                        fault_d = 2'd3;
                    end
                    default: begin
                        state_d = st_trap;
                        fault_d = 2'd1;
                    end
                endcase
            end
            st_exec_r: begin
                alu_src_a = 2'd2;
                state_d   = st_alu_wb;
            end
            st_exec_i: begin
                alu_src_a = 2'd2;
                alu_src_b = 2'd1;
                state_d   = st_alu_wb;
            end
            st_exec_u: begin
                alu_src_a     = (opcode == OP_LUI) ? 2'd3 : 2'd1;
                alu_src_b     = 2'd1;
                alu_force_add = 1'b1;
                state_d       = st_alu_wb;
            end
            st_alu_wb: begin
                reg_write = 1'b1;
                retire    = 1'b1;
                state_d   = st_fetch;
            end
            st_mem_adr: begin
                alu_src_a     = 2'd2;
                alu_src_b     = 2'd1;
                alu_force_add = 1'b1;
                state_d       = (opcode == OP_LOAD) ? st_mem_rd : st_mem_wr;
            end
            st_mem_rd: begin
                waiting   = 1'b1;
                mem_valid = 1'b1;
                adr_src   = 1'b1;
                if (mem_ready) state_d = st_mem_wb;
            end
            st_mem_wb: begin
                result_src = 2'd1;
                reg_write  = 1'b1;
                retire     = 1'b1;
                state_d    = st_fetch;
            end
            st_mem_wr: begin
                waiting   = 1'b1;
                mem_valid = 1'b1;
                mem_we    = 1'b1;
                adr_src   = 1'b1;
                if (mem_ready) begin
                    retire  = 1'b1;
                    state_d = st_fetch;
                end
            end
            st_branch: begin
                // Not taken: PC already holds PC+4 from FETCH.
                pc_src   = 1'b1;
                pc_write = br_taken;
                retire   = 1'b1;
                state_d  = st_fetch;
            end
            st_jalr_adr: begin
                alu_src_a     = 2'd2;
                alu_src_b     = 2'd1;
                alu_force_add = 1'b1;
                state_d       = st_jump;
            end
            st_jump: begin
                // rd <- OldPC+4 from the live ALU; PC <- target held in ALUOut.
                alu_src_a     = 2'd1;
                alu_src_b     = 2'd2;
                alu_force_add = 1'b1;
                result_src    = 2'd2;
                reg_write     = 1'b1;
                pc_src        = 1'b1;
                pc_write      = 1'b1;
                retire        = 1'b1;
                state_d       = st_fetch;
            end
            st_trap: ;
            default: state_d = st_trap;
        endcase

        // A completing access in the last allowed cycle beats the timeout.
        if (waiting && !mem_ready && (wait_q == WAIT_W'(TIMEOUT - 1))) begin
            state_d = st_trap;
            fault_d = 2'd2;
        end

        if (state_d != state_q)          wait_d = '0;
        else if (waiting && !mem_ready)  wait_d = wait_q + 1'b1;
        else                             wait_d = wait_q;

        instret_d = retire ? instret_q + 1'b1 : instret_q;

        // Reset suppresses every control output immediately, not just at the edge.
        if (reset) begin
            pc_write      = 1'b0;
            old_pc_write  = 1'b0;
            ir_write      = 1'b0;
            pc_src        = 1'b0;
            adr_src       = 1'b0;
            mem_valid     = 1'b0;
            mem_we        = 1'b0;
            reg_write     = 1'b0;
            result_src    = 2'd0;
            alu_src_a     = 2'd0;
            alu_src_b     = 2'd0;
            alu_force_add = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= st_fetch;
            wait_q    <= '0;
            fault_q   <= 2'd0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            fault_q   <= fault_d;
            instret_q <= instret_d;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

    typedef struct packed {
        logic       pcw, opcw, irw, pcsrc, adr, mv, we, rw;
        logic [1:0] rs, a, b;
        logic       fa;
    } ctl_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] opcode = 7'b0110011;
    logic       br_taken = 1'b0;
    logic       mem_ready = 1'b1;

    logic        pcw0, opcw0, irw0, pcsrc0, adr0, mv0, we0, rw0, fa0;
    logic [1:0]  rs0, a0, b0, fault0;
    logic [3:0]  fmt0;
    logic [31:0] instret0;
    logic        pcw1, opcw1, irw1, pcsrc1, adr1, mv1, we1, rw1, fa1;
    logic [1:0]  rs1, a1, b1, fault1;
    logic [3:0]  fmt1;
    logic [1:0]  instret1;

    ctl_t got0, got1;
    assign got0 = {pcw0, opcw0, irw0, pcsrc0, adr0, mv0, we0, rw0, rs0, a0, b0, fa0};
    assign got1 = {pcw1, opcw1, irw1, pcsrc1, adr1, mv1, we1, rw1, rs1, a1, b1, fa1};

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [31:0] exp_instret = '0;

    localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, LD = 7'b0000011;
    localparam logic [6:0] ST = 7'b0100011, BR = 7'b1100011, JAL = 7'b1101111;
    localparam logic [6:0] JALR = 7'b1100111, LUI = 7'b0110111, AUIPC = 7'b0010111;
    localparam logic [6:0] SYS = 7'b1110011;

    logic [6:0] ops [9] = '{R, I, LD, ST, BR, JAL, JALR, LUI, AUIPC};

    multicycle_ctrl #(.CNT_W(32), .TIMEOUT(8)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .br_taken(br_taken),
        .mem_ready(mem_ready), .pc_write(pcw0), .old_pc_write(opcw0), .ir_write(irw0),
        .pc_src(pcsrc0), .adr_src(adr0), .mem_valid(mv0), .mem_we(we0), .reg_write(rw0),
        .result_src(rs0), .alu_src_a(a0), .alu_src_b(b0), .alu_force_add(fa0),
        .fmt(fmt0), .fault_code(fault0), .instret(instret0)
    );

    // Narrow counter instance exercises instret wrap-around.
    multicycle_ctrl #(.CNT_W(2), .TIMEOUT(8)) dut_w (
        .clk(clk), .reset(reset), .opcode(opcode), .br_taken(br_taken),
        .mem_ready(mem_ready), .pc_write(pcw1), .old_pc_write(opcw1), .ir_write(irw1),
        .pc_src(pcsrc1), .adr_src(adr1), .mem_valid(mv1), .mem_we(we1), .reg_write(rw1),
        .result_src(rs1), .alu_src_a(a1), .alu_src_b(b1), .alu_force_add(fa1),
        .fmt(fmt1), .fault_code(fault1), .instret(instret1)
    );

    always #5 clk = ~clk;

    function automatic ctl_t mk(input int pcw, input int opcw, input int irw, input int pcsrc,
                                input int adr, input int mv, input int we, input int rw,
                                input int rs, input int a, input int b, input int fa);
        ctl_t c;
        c.pcw = 1'(pcw); c.opcw = 1'(opcw); c.irw = 1'(irw); c.pcsrc = 1'(pcsrc);
        c.adr = 1'(adr); c.mv = 1'(mv); c.we = 1'(we); c.rw = 1'(rw);
        c.rs = 2'(rs); c.a = 2'(a); c.b = 2'(b); c.fa = 1'(fa);
        return c;
    endfunction

    function automatic logic [3:0] exp_fmt(input logic [6:0] op);
        case (op)
            R: return 4'd0;   I: return 4'd1;    LD: return 4'd2;   SYS: return 4'd3;
            ST: return 4'd4;  BR: return 4'd5;   JAL: return 4'd6;  JALR: return 4'd7;
            LUI: return 4'd8; AUIPC: return 4'd9;
            default: return 4'd10;
        endcase
    endfunction

    task automatic check_ctl(input ctl_t exp, input string tag);
        checks++;
        assert (got0 === exp) else begin
            errors++;
            $error("FAIL %s: controls observed %h expected %h", tag, got0, exp);
        end
        checks++;
        assert (got1 === exp) else begin
            errors++;
            $error("FAIL %s(narrow): controls observed %h expected %h", tag, got1, exp);
        end
    endtask

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_status(input string tag, input logic [1:0] fault);
        check_val({tag, "_fault"}, 32'(fault0), 32'(fault));
        check_val({tag, "_fault_n"}, 32'(fault1), 32'(fault));
        check_val({tag, "_instret"}, instret0, exp_instret);
        check_val({tag, "_instret_n"}, 32'(instret1), 32'(exp_instret[1:0]));
    endtask

    task automatic cyc(input logic [6:0] op, input logic mr, input logic bt);
        @(negedge clk);
        reset = 1'b0;
        opcode = op;
        mem_ready = mr;
        br_taken = bt;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        mem_ready = 1'b1;
        br_taken = 1'b1;
        #1;
        check_ctl('0, "reset_gated");
        exp_instret = '0;
    endtask

    // Expected per-cycle controls follow the instruction class directly.
    task automatic run_instr(input logic [6:0] op, input logic taken, input int fw, input int mw);
        ctl_t fetch_w = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2, 1);
        ctl_t fetch_r = mk(1, 1, 1, 0, 0, 1, 0, 0, 0, 0, 2, 1);
        ctl_t alu_wb  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        ctl_t adr_c   = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 1, 1);
        ctl_t jump_c  = mk(1, 0, 0, 1, 0, 0, 0, 1, 2, 1, 2, 1);
        ctl_t rd_c    = mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        ctl_t wr_c    = mk(0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0);
        for (int w = 0; w < fw; w++) begin
            cyc(op, 1'b0, 1'b0);
            check_ctl(fetch_w, "fetch_wait");
            if (w == 0) check_status("start", 2'd0);
        end
        cyc(op, 1'b1, 1'b0);
        check_ctl(fetch_r, "fetch");
        if (fw == 0) check_status("start", 2'd0);
        cyc(op, 1'b0, 1'b0);
        check_ctl(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1), "decode");
        check_val("fmt", 32'(fmt0), 32'(exp_fmt(op)));
        case (op)
            R, I: begin
                cyc(op, 1'b0, 1'b0);
                check_ctl(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2, (op == I) ? 1 : 0, 0), "exec");
                cyc(op, 1'b0, 1'b0);
                check_ctl(alu_wb, "alu_wb");
            end
            LUI, AUIPC: begin
                cyc(op, 1'b0, 1'b0);
                check_ctl(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, (op == LUI) ? 3 : 1, 1, 1), "exec_u");
                cyc(op, 1'b0, 1'b0);
                check_ctl(alu_wb, "alu_wb");
            end
            LD, ST: begin
                cyc(op, 1'b0, 1'b0);
                check_ctl(adr_c, "mem_adr");
                for (int w = 0; w < mw; w++) begin
                    cyc(op, 1'b0, 1'b0);
                    check_ctl((op == LD) ? rd_c : wr_c, "mem_wait");
                end
                cyc(op, 1'b1, 1'b0);
                check_ctl((op == LD) ? rd_c : wr_c, "mem_done");
                if (op == LD) begin
                    cyc(op, 1'b0, 1'b0);
                    check_ctl(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0), "mem_wb");
                end
            end
            BR: begin
                cyc(op, 1'b0, taken);
                check_ctl(mk(taken ? 1 : 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0), "branch");
            end
            JAL: begin
                cyc(op, 1'b0, 1'b0);
                check_ctl(jump_c, "jal");
            end
            default: begin
                cyc(op, 1'b0, 1'b0);
                check_ctl(adr_c, "jalr_adr");
                cyc(op, 1'b0, 1'b0);
                check_ctl(jump_c, "jalr_jump");
            end
        endcase
        exp_instret = exp_instret + 1;
    endtask

    task automatic trap_op(input logic [6:0] op, input logic [1:0] fault);
        cyc(op, 1'b1, 1'b0);
        check_ctl(mk(1, 1, 1, 0, 0, 1, 0, 0, 0, 0, 2, 1), "trap_fetch");
        cyc(op, 1'b0, 1'b0);
        check_ctl(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1), "trap_decode");
        check_val("trap_fmt", 32'(fmt0), 32'(exp_fmt(op)));
        check_val("decode_fault", 32'(fault0), 32'd0);
        for (int k = 0; k < 3; k++) begin
            cyc(op, 1'b1, 1'b1);
            check_ctl('0, "trap_ctl");
            check_status("trap", fault);
        end
    endtask

    initial begin
        // Reset state: outputs gated even with mem_ready high.
        @(negedge clk);
        #1;
        check_ctl('0, "reset_hold");
        @(negedge clk);
        #1;
        check_status("reset", 2'd0);

        // Directed: R-type, slow load, branch not-taken/taken, JALR.
        run_instr(R, 1'b0, 0, 0);
        run_instr(LD, 1'b0, 0, 3);
        run_instr(BR, 1'b0, 0, 0);
        run_instr(BR, 1'b1, 0, 0);
        run_instr(JALR, 1'b0, 0, 0);

        // Random instruction stream with random memory stalls.
        for (int n = 0; n < 60; n++) begin
            run_instr(ops[$urandom_range(0, 8)], 1'($urandom_range(0, 1)),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end

        // Fetch timeout: 8 stalled cycles, then TRAP with fault 2.
        for (int w = 0; w < 8; w++) begin
            cyc(R, 1'b0, 1'b0);
            check_ctl(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2, 1), "to_wait");
            check_status("to_wait", 2'd0);
        end
        cyc(R, 1'b1, 1'b1);
        check_ctl('0, "to_trap");
        check_status("to_trap", 2'd2);
        cyc(R, 1'b1, 1'b1);
        check_ctl('0, "to_trap2");
        check_status("to_trap2", 2'd2);
        do_reset();
        cyc(R, 1'b0, 1'b0);
        check_ctl(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2, 1), "post_reset");
        check_status("post_reset", 2'd0);

        // Illegal opcode and SYSTEM.
        trap_op(7'b0000000, 2'd1);
        do_reset();
        trap_op(SYS, 2'd3);
        do_reset();

        // Reset during MEM_WR: no write, no retire.
        run_instr(R, 1'b0, 0, 0);
        cyc(ST, 1'b1, 1'b0);
        cyc(ST, 1'b0, 1'b0);
        cyc(ST, 1'b0, 1'b0);
        cyc(ST, 1'b0, 1'b0);
        check_ctl(mk(0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0), "mem_wr_stall");
        do_reset();
        cyc(ST, 1'b0, 1'b0);
        check_ctl(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2, 1), "abort_fetch");
        check_status("abort", 2'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
